// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin sharing of one signed 8x8 radix-4 Booth multiplier among
// N_REQ requesters. Stage 1 registers the granted operands, stage 2
// registers the product together with the owning requester index.
module mult_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   i_req_valid,
   output logic [N_REQ-1:0]   o_req_ready,
   input  logic [N_REQ*8-1:0] i_req_m,
   input  logic [N_REQ*8-1:0] i_req_q,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic [ID_W-1:0]    o_res_id,
   output logic [15:0]        o_res_product,
   output logic               o_busy
);

   genvar gi;

   // Stage 1: operand register
   logic            r_s1_valid;
   logic [7:0]      r_s1_m;
   logic [7:0]      r_s1_q;
   logic [ID_W-1:0] r_s1_id;

   // Stage 2: result register
   logic            r_res_valid;
   logic [15:0]     r_res_product;
   logic [ID_W-1:0] r_res_id;

   // Round-robin search start
   logic [ID_W-1:0] r_rr_ptr;

   logic            w_s2_load;
   logic            w_s1_can_load;
   logic            w_grant_any;
   logic [ID_W-1:0] w_grant_id;
   logic [N_REQ-1:0] w_grant;
   logic            w_hs;
   logic [ID_W-1:0] w_ptr_next;
   logic [7:0]      w_m_arr [N_REQ];
   logic [7:0]      w_q_arr [N_REQ];
   logic [15:0]     w_m_ext;
   logic [8:0]      w_q_ext;
   logic [15:0]     w_pp [4];
   logic [15:0]     w_product;

   // Stage 2 takes stage 1 whenever the result slot is empty or being drained;
   // stage 1 can take new operands when empty or emptying this cycle.
   assign w_s2_load     = r_s1_valid & (~r_res_valid | i_res_ready);
   assign w_s1_can_load = ~r_s1_valid | w_s2_load;

   // First valid requester searching upward from the pointer, wrapping at N_REQ
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_id  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_grant_any && i_req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
            w_grant_any = 1'b1;
            w_grant_id  = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
         end
      end
   end

   assign w_grant     = w_grant_any ? (N_REQ'(1) << w_grant_id) : '0;
   // Ready is held low while reset is asserted so nothing looks accepted then.
   assign o_req_ready = w_grant & {N_REQ{w_s1_can_load & ~rst}};
   assign w_hs        = w_grant_any & w_s1_can_load;
   assign w_ptr_next  = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;

   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_ops
         assign w_m_arr[gi] = i_req_m[8*gi +: 8];
         assign w_q_arr[gi] = i_req_q[8*gi +: 8];
      end
   endgenerate

   // Booth recoding: the multiplier gets an implicit zero below its LSB, each
   // overlapping 3-bit window selects a digit in {-2,-1,0,+1,+2}. All partial
   // products are formed at 16 bits, so -128*-128 and friends come out exact.
   assign w_m_ext = {{8{r_s1_m[7]}}, r_s1_m};
   assign w_q_ext = {r_s1_q, 1'b0};

   generate
      for (gi = 0; gi < 4; gi++) begin : g_booth
         logic [15:0] w_raw;
         // Select the partial product for this Booth digit
         always_comb begin
            case (w_q_ext[2*gi+2 -: 3])
               3'b001, 3'b010: w_raw = w_m_ext;
               3'b011:         w_raw = w_m_ext << 1;
               3'b100:         w_raw = -(w_m_ext << 1);
               3'b101, 3'b110: w_raw = -w_m_ext;
               default:        w_raw = '0;
            endcase
         end
         assign w_pp[gi] = w_raw << (2 * gi);
      end
   endgenerate

   assign w_product = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];

   // Stage 1: load on handshake, otherwise empty when its content moves on
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_m     <= '0;
         r_s1_q     <= '0;
         r_s1_id    <= '0;
      end else if (w_hs) begin
         r_s1_valid <= 1'b1;
         r_s1_m     <= w_m_arr[w_grant_id];
         r_s1_q     <= w_q_arr[w_grant_id];
         r_s1_id    <= w_grant_id;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 2: capture product and tag, or go empty once the consumer takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_valid   <= 1'b0;
         r_res_product <= '0;
         r_res_id      <= '0;
      end else if (w_s2_load) begin
         r_res_valid   <= 1'b1;
         r_res_product <= w_product;
         r_res_id      <= r_s1_id;
      end else if (i_res_ready) begin
         r_res_valid   <= 1'b0;
      end
   end

   // Pointer moves past the requester that was just served
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_hs) begin
         r_rr_ptr <= w_ptr_next;
      end
   end

   assign o_res_valid   = r_res_valid;
   assign o_res_product = r_res_product;
   assign o_res_id      = r_res_id;
   assign o_busy        = r_s1_valid | r_res_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of accepted requests.
module tb_mult_share_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_ready;
   logic [N*8-1:0] req_m = '0;
   logic [N*8-1:0] req_q = '0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [1:0]   res_id;
   logic [15:0]  res_product;
   logic         busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mult_share_arbiter #(.N_REQ(N), .ID_W(2)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_m(req_m), .i_req_q(req_q),
      .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_id(res_id), .o_res_product(res_product), .o_busy(busy)
   );

   // Reference model: every accepted request is queued with the cycle it was
   // accepted; it becomes the visible result two edges later, in order.
   typedef struct { int id; logic [15:0] prod; int acc; } item_t;
   item_t mq[$];
   int    m_ptr = 0;
   int    cyc   = 0;
   logic [N-1:0] exp_ready;
   logic  exp_rv;
   int    exp_id;
   logic [15:0] exp_prod;
   int    exp_g;

   function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   task automatic model_predict();
      exp_g = -1;
      for (int k = 0; k < N; k++)
         if (exp_g < 0 && req_valid[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
      exp_rv   = (mq.size() > 0) && (cyc - mq[0].acc >= 2);
      exp_id   = exp_rv ? mq[0].id : 0;
      exp_prod = exp_rv ? mq[0].prod : 16'h0;
      exp_ready = '0;
      if (exp_g >= 0 && (mq.size() < 2 || res_ready)) exp_ready[exp_g] = 1'b1;
   endtask

   task automatic model_commit();
      item_t it;
      if (exp_rv && res_ready) begin
         $display("txn result id=%0d product=%h", mq[0].id, mq[0].prod);
         void'(mq.pop_front());
      end
      if (exp_ready != '0) begin
         it.id   = exp_g;
         it.prod = ref_prod(req_m[8*exp_g +: 8], req_q[8*exp_g +: 8]);
         it.acc  = cyc;
         mq.push_back(it);
         m_ptr = (exp_g + 1) % N;
      end
      cyc++;
   endtask

   task automatic model_clear();
      mq.delete();
      m_ptr = 0;
      cyc   = 0;
   endtask

   // Keeps the model in step while emptying the pipeline
   task automatic drain(input int n);
      req_valid = '0;
      res_ready = 1'b1;
      for (int c = 0; c < n; c++) begin
         @(negedge clk); model_predict(); model_commit();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      req_valid = '1;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      total++; if (res_product !== 16'h0 || res_id !== 2'd0) begin bad++; $display("FAIL reset_result got=%h/%0d want=0000/0", res_product, res_id); end
      @(posedge clk); #1 rst = 1'b0;
      model_clear();
      @(negedge clk); model_predict();
      total++; if (req_ready !== exp_ready || req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_ready got=%b want=0001", req_ready); end
      req_valid = '0;
      model_predict(); model_commit();
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      res_ready = 1'b1;
      req_valid = 4'b0010;
      req_m[15:8] = 8'd3;
      req_q[15:8] = 8'hFB;
      @(negedge clk); model_predict();
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b want=0010", req_ready); end
      model_commit();
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); model_predict();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", res_valid); end
      model_commit();
      @(posedge clk); #1;
      @(negedge clk); model_predict();
      total++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_product !== 16'hFFF1) begin
         bad++; $display("FAIL single_result got=%b/%0d/%h want=1/1/fff1", res_valid, res_id, res_product); end
      total++; if (dut.r_rr_ptr !== 2'd2) begin bad++; $display("FAIL single_ptr got=%0d want=2", dut.r_rr_ptr); end
      model_commit();
      @(posedge clk); #1;
      @(negedge clk); model_predict();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
      model_commit();
      @(posedge clk); #1;
   endtask

   task automatic test_corners();
      logic [7:0]  cm [4];
      logic [7:0]  cq [4];
      logic [15:0] cp [4];
      int seen;
      cm = '{8'h80, 8'h80, 8'h7F, 8'h00};
      cq = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
      cp = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};
      seen = 0;
      res_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         req_valid = '0;
         if (c < 4) begin
            req_valid[c] = 1'b1;
            req_m[8*c +: 8] = cm[c];
            req_q[8*c +: 8] = cq[c];
         end
         @(negedge clk); model_predict();
         total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL corner_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
         total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL corner_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
         if (res_valid && seen < 4) begin
            total++; if (res_id !== 2'(seen) || res_product !== cp[seen]) begin
               bad++; $display("FAIL corner_product n=%0d got=%0d/%h want=%0d/%h", seen, res_id, res_product, seen, cp[seen]); end
            seen++;
         end
         model_commit();
         @(posedge clk); #1;
      end
      total++; if (seen !== 4) begin bad++; $display("FAIL corner_count got=%0d want=4", seen); end
   endtask

   task automatic test_fairness();
      int start, nhs;
      start = m_ptr;
      nhs = 0;
      res_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         req_m[8*i +: 8] = 8'($urandom);
         req_q[8*i +: 8] = 8'($urandom);
      end
      req_valid = '1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk); model_predict();
         total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL fair_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
         total++; if (req_ready !== (4'b0001 << ((start + nhs) % N))) begin
            bad++; $display("FAIL fair_order c=%0d got=%b want_id=%0d", c, req_ready, (start + nhs) % N); end
         nhs++;
         total++; if (res_valid !== (c >= 2)) begin bad++; $display("FAIL fair_rate c=%0d got=%b want=%b", c, res_valid, c >= 2); end
         if (exp_rv) begin
            total++; if (res_id !== exp_id[1:0] || res_product !== exp_prod) begin
               bad++; $display("FAIL fair_result c=%0d got=%0d/%h want=%0d/%h", c, res_id, res_product, exp_id, exp_prod); end
         end
         model_commit();
         @(posedge clk); #1;
         for (int i = 0; i < N; i++)
            if (exp_ready[i]) begin
               req_m[8*i +: 8] = 8'($urandom);
               req_q[8*i +: 8] = 8'($urandom);
            end
      end
      drain(4);
   endtask

   task automatic test_backpressure();
      int nhs;
      logic [15:0] hold_p;
      logic [1:0]  hold_id;
      nhs = 0;
      hold_p = '0;
      hold_id = '0;
      for (int i = 0; i < N; i++) begin
         req_m[8*i +: 8] = 8'($urandom);
         req_q[8*i +: 8] = 8'($urandom);
      end
      req_valid = '1;
      res_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c == 5) res_ready = 1'b1;
         if (c == 9) req_valid = '0;
         @(negedge clk); model_predict();
         total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
         total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
         if (exp_rv) begin
            total++; if (res_id !== exp_id[1:0] || res_product !== exp_prod) begin
               bad++; $display("FAIL bp_result c=%0d got=%0d/%h want=%0d/%h", c, res_id, res_product, exp_id, exp_prod); end
         end
         if (c < 5) begin
            if (req_ready != '0) nhs++;
            if (c >= 1) begin
               total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy c=%0d got=%b want=1", c, busy); end
            end
            if (c == 2) begin hold_p = res_product; hold_id = res_id; end
            if (c > 2) begin
               total++; if (res_product !== hold_p || res_id !== hold_id) begin
                  bad++; $display("FAIL bp_stable c=%0d got=%0d/%h want=%0d/%h", c, res_id, res_product, hold_id, hold_p); end
            end
         end
         model_commit();
         @(posedge clk); #1;
         for (int i = 0; i < N; i++)
            if (exp_ready[i]) begin
               req_m[8*i +: 8] = 8'($urandom);
               req_q[8*i +: 8] = 8'($urandom);
            end
      end
      total++; if (nhs !== 2) begin bad++; $display("FAIL bp_handshakes got=%0d want=2", nhs); end
      drain(4);
   endtask

   task automatic test_wrap_withdraw();
      int id2_seen;
      id2_seen = 0;
      res_ready = 1'b1;
      req_valid = 4'b1000;
      req_m[31:24] = 8'd9;   req_q[31:24] = 8'hF7;
      @(negedge clk); model_predict();
      total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b want=1000", req_ready); end
      model_commit();
      @(posedge clk); #1;
      total++; if (dut.r_rr_ptr !== 2'd0) begin bad++; $display("FAIL wrap_ptr got=%0d want=0", dut.r_rr_ptr); end
      req_valid = 4'b1001;
      req_m[7:0] = 8'd100;   req_q[7:0] = 8'd3;
      req_m[31:24] = 8'd5;   req_q[31:24] = 8'd5;
      @(negedge clk); model_predict();
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b want=0001", req_ready); end
      model_commit();
      @(posedge clk); #1;
      res_ready = 1'b0;
      req_valid = 4'b0100;
      req_m[23:16] = 8'd77;  req_q[23:16] = 8'd77;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) req_valid = 4'b0000;
         if (c == 2) res_ready = 1'b1;
         @(negedge clk); model_predict();
         total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL wd_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
         total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL wd_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
         if (exp_rv) begin
            total++; if (res_id !== exp_id[1:0] || res_product !== exp_prod) begin
               bad++; $display("FAIL wd_result c=%0d got=%0d/%h want=%0d/%h", c, res_id, res_product, exp_id, exp_prod); end
         end
         if (res_valid && res_id == 2'd2) id2_seen++;
         model_commit();
         @(posedge clk); #1;
      end
      total++; if (id2_seen !== 0) begin bad++; $display("FAIL wd_withdrawn got=%0d want=0", id2_seen); end
   endtask

   task automatic test_reset_mid();
      req_valid = '1;
      res_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); model_predict(); model_commit();
         @(posedge clk); #1;
      end
      @(negedge clk); #2 rst = 1'b1;
      #1;
      total++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
         bad++; $display("FAIL rstmid_async got=%b/%b/%b want=0/0/0000", res_valid, busy, req_ready); end
      req_valid = 4'b1010;
      res_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      model_clear();
      @(negedge clk); model_predict();
      total++; if (req_ready !== 4'b0010 || req_ready !== exp_ready) begin bad++; $display("FAIL rstmid_grant got=%b want=0010", req_ready); end
      model_commit();
      @(posedge clk); #1 req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); model_predict();
         total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL rstmid_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
         if (exp_rv) begin
            total++; if (res_id !== exp_id[1:0] || res_product !== exp_prod) begin
               bad++; $display("FAIL rstmid_result c=%0d got=%0d/%h want=%0d/%h", c, res_id, res_product, exp_id, exp_prod); end
         end
         model_commit();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      req_valid = '0;
      for (int c = 0; c < 400; c++) begin
         res_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk); model_predict();
         total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
         total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
         total++; if (busy !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, mq.size() > 0); end
         if (exp_rv) begin
            total++; if (res_id !== exp_id[1:0] || res_product !== exp_prod) begin
               bad++; $display("FAIL rnd_result c=%0d got=%0d/%h want=%0d/%h", c, res_id, res_product, exp_id, exp_prod); end
         end
         model_commit();
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (exp_ready[i] || !req_valid[i]) begin
               if (exp_ready[i] || $urandom_range(0, 2) == 0) begin
                  req_valid[i] = ($urandom_range(0, 3) != 0);
                  req_m[8*i +: 8] = 8'($urandom);
                  req_q[8*i +: 8] = 8'($urandom);
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      drain(4);
   endtask

   initial begin
      test_reset();
      test_single();
      test_corners();
      test_fairness();
      test_backpressure();
      test_wrap_withdraw();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
